mul8_err_stats: RTL and testbench

- Error-characterisation stage directly downstream of the 8x8 approximate multiplier (mul8).
- Takes each operand pair A, B and the approximate product O from mul8, and computes the exact product internally.
- Accumulates error statistics over a window of NUM_SAMPLES accepted samples: sum of absolute error, worst-case error, and count of erroneous samples.
- Used in characterisation runs so that MAE, WCE and EP can be derived for each candidate circuit.

---
 rtl/mul8_err_pkg.sv | 34 +++
 rtl/mul8_err_absdiff.sv | 58 +++++
 rtl/mul8_err_stats.sv | 115 +++++++++++
 tb/tb_mul8_err_stats.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul8_err_pkg.sv
// Shared types for the mul8 error-statistics stage.
// Optional squared-error path is enabled by MUL8_ERR_SQ_EN.
package mul8_err_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned SQ_W   = 2 * PROD_W;

    // Width of the absolute-error sum for a given counter width.
    function automatic int unsigned sum_w(input int unsigned cnt_w);
        return PROD_W + cnt_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } err_state_t;

    typedef struct packed {
        logic [PROD_W-1:0] o;
        logic [PROD_W-1:0] exact;
    } s1_t;

    typedef struct packed {
`ifdef MUL8_ERR_SQ_EN
        logic [SQ_W-1:0]   sq;
`endif
        logic [PROD_W-1:0] abs_err;
        logic              nz;
    } s2_t;

endpackage

// File: rtl/mul8_err_absdiff.sv
// Two-stage registered exact-product and absolute-difference pipe (S1, S2).
// With MUL8_ERR_SQ_EN the squared error is also produced in S2.
module mul8_err_absdiff
    import mul8_err_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [PROD_W-1:0] in_o,
    output logic              out_valid,
    output s2_t               out_data,
    output logic              pipe_busy_c
);

    logic              s1_valid;
    s1_t               s1;
    logic [PROD_W-1:0] abs_err_c;

    always_comb begin
        abs_err_c = (s1.o >= s1.exact) ? (s1.o - s1.exact) : (s1.exact - s1.o);
    end

    assign pipe_busy_c = s1_valid | out_valid;

    // Valid bits: flush discards whatever is in flight, including a same-cycle input.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            out_data <= '0;
        end else begin
            if (in_valid) begin
                s1.o     <= in_o;
                s1.exact <= PROD_W'(in_a) * PROD_W'(in_b);
            end
            if (s1_valid) begin
                out_data.abs_err <= abs_err_c;
                out_data.nz      <= (abs_err_c != '0);
`ifdef MUL8_ERR_SQ_EN
                out_data.sq      <= SQ_W'(abs_err_c) * SQ_W'(abs_err_c);
`endif
            end
        end
    end

endmodule

// File: rtl/mul8_err_stats.sv
// Error statistics (count, sum, max of |O - A*B|) over a window of samples.
// Define MUL8_ERR_SQ_EN to add the sum-of-squared-error output.
module mul8_err_stats
    import mul8_err_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned NUM_SAMPLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_a,
    input  logic [OP_W-1:0]           in_b,
    input  logic [PROD_W-1:0]         in_o,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          sample_cnt,
    output logic [CNT_W-1:0]          err_cnt,
    output logic [sum_w(CNT_W)-1:0]   sum_abs_err,
    output logic [PROD_W-1:0]         max_abs_err
`ifdef MUL8_ERR_SQ_EN
    ,
    output logic [SQ_W+CNT_W-1:0]     sum_sq_err
`endif
);

    localparam int unsigned      SUM_W = sum_w(CNT_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_SAMPLES - 1);

    err_state_t       state;
    logic [CNT_W-1:0] acc_cnt;
    logic             accept_c;
    logic             s2_valid;
    s2_t              s2;
    logic             pipe_busy_c;

    assign accept_c = in_valid & in_ready;

    mul8_err_absdiff u_absdiff (
        .clk         (clk),
        .rst         (rst),
        .flush       (start),
        .in_valid    (accept_c),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_o        (in_o),
        .out_valid   (s2_valid),
        .out_data    (s2),
        .pipe_busy_c (pipe_busy_c)
    );

    // Window control; start from any state restarts with a clean window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc_cnt  <= '0;
        end else if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            acc_cnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept_c) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt == LAST) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!pipe_busy_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Accumulators; a restart clears them and suppresses the same-edge update.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
`ifdef MUL8_ERR_SQ_EN
            sum_sq_err  <= '0;
`endif
        end else if (s2_valid) begin
            sample_cnt  <= sample_cnt + CNT_W'(1);
            err_cnt     <= err_cnt + CNT_W'(s2.nz);
            sum_abs_err <= sum_abs_err + SUM_W'(s2.abs_err);
            if (s2.abs_err > max_abs_err) begin
                max_abs_err <= s2.abs_err;
            end
`ifdef MUL8_ERR_SQ_EN
            sum_sq_err  <= sum_sq_err + (SQ_W + CNT_W)'(s2.sq);
`endif
        end
    end

endmodule

// File: tb/tb_mul8_err_stats.sv
// Directed bench for mul8_err_stats (window of 4) with a queue-based scoreboard.
// Checks sum_sq_err too when MUL8_ERR_SQ_EN is defined.
module tb_mul8_err_stats;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [7:0]    in_a, in_b;
    logic [15:0]   in_o;
    logic          in_ready, busy, done;
    logic [CW-1:0] sample_cnt, err_cnt;
    logic [CW+15:0] sum_abs_err;
    logic [15:0]   max_abs_err;
`ifdef MUL8_ERR_SQ_EN
    logic [CW+31:0] sum_sq_err;
`endif

    always #5 clk = ~clk;

    mul8_err_stats #(.CNT_W(CW), .NUM_SAMPLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_o        (in_o),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err)
`ifdef MUL8_ERR_SQ_EN
        ,
        .sum_sq_err  (sum_sq_err)
`endif
    );

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_t;
    typedef struct {
        longint unsigned abs_err;
        int              due;
    } pend_t;

    pend_t           q[$];
    mstate_t         ms;
    int              m_acc, edge_n, last_edge;
    longint unsigned m_cnt, m_err, m_sum, m_max, m_sq;
    int              errors = 0;
    int              checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        q.delete();
        m_acc = 0;
        m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_sq = 0;
    endtask

    function automatic longint unsigned abs_of(input int a, input int b, input int o);
        int ex;
        ex = a * b;
        return (o >= ex) ? longint'(o - ex) : longint'(ex - o);
    endfunction

    // One clock: drive inputs, advance the model, compare every output.
    task automatic cycle(input logic v, input int a, input int b, input int o,
                         input logic st, input logic r);
        logic  acc;
        pend_t p;
        in_valid = v; in_a = 8'(a); in_b = 8'(b); in_o = 16'(o);
        start = st; rst = r;
        acc = v && (ms == M_RUN);
        @(posedge clk);
        #1;
        edge_n++;
        if (r) begin
            clear_model();
            ms = M_IDLE;
        end else if (st) begin
            clear_model();
            ms = M_RUN;
        end else begin
            if (ms == M_DRAIN && edge_n == last_edge + 3) ms = M_DONE;
            if (acc) begin
                p.abs_err = abs_of(a, b, o);
                p.due     = edge_n + 2;
                q.push_back(p);
                m_acc++;
                if (m_acc == N) begin
                    ms = M_DRAIN;
                    last_edge = edge_n;
                end
            end
            while (q.size() > 0 && q[0].due == edge_n) begin
                p = q.pop_front();
                m_cnt++;
                if (p.abs_err != 0) m_err++;
                m_sum += p.abs_err;
                if (p.abs_err > m_max) m_max = p.abs_err;
                m_sq += p.abs_err * p.abs_err;
            end
        end
        in_valid = 1'b0; start = 1'b0; rst = 1'b0;
        chk("in_ready", 64'(in_ready), 64'(ms == M_RUN));
        chk("busy", 64'(busy), 64'(ms == M_RUN || ms == M_DRAIN));
        chk("done", 64'(done), 64'(ms == M_DONE));
        chk("sample_cnt", 64'(sample_cnt), m_cnt);
        chk("err_cnt", 64'(err_cnt), m_err);
        chk("sum_abs_err", 64'(sum_abs_err), m_sum);
        chk("max_abs_err", 64'(max_abs_err), m_max);
`ifdef MUL8_ERR_SQ_EN
        chk("sum_sq_err", 64'(sum_sq_err), m_sq);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic rnd_sample(input logic st);
        int a, b, ex, d, o;
        a  = int'($urandom_range(0, 255));
        b  = int'($urandom_range(0, 255));
        ex = a * b;
        d  = int'($urandom_range(0, 40));
        o  = (ex + d > 65535) ? ex - d : ex + d;
        cycle(1'b1, a, b, o, st, 1'b0);
    endtask

    initial begin
        int ea[4], eb[4], e_o[4];
        ea = '{3, 7, 255, 0};   eb = '{5, 9, 255, 200}; e_o = '{15, 63, 65025, 0};
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_o = '0;
        edge_n = 0; last_edge = 0;
        clear_model();
        ms = M_IDLE;

        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        cycle(1'b1, 3, 5, 99, 1'b0, 1'b0);
        cycle(1'b1, 4, 4, 0, 1'b0, 1'b0);

        // Exact products only: no errors expected.
        do_start();
        for (int i = 0; i < 4; i++) cycle(1'b1, ea[i], eb[i], e_o[i], 1'b0, 1'b0);
        idle(4);
        chk("w1_done", 64'(done), 64'd1);
        chk("w1_cnt", 64'(sample_cnt), 64'd4);
        cycle(1'b1, 9, 9, 0, 1'b0, 1'b0);
        cycle(1'b1, 9, 9, 0, 1'b0, 1'b0);

        // Known errors: |96-100|=4, 0, |10-6|=4, 0.
        do_start();
        cycle(1'b1, 10, 10, 96, 1'b0, 1'b0);
        cycle(1'b1, 255, 255, 65025, 1'b0, 1'b0);
        cycle(1'b1, 2, 3, 10, 1'b0, 1'b0);
        cycle(1'b1, 1, 1, 1, 1'b0, 1'b0);
        idle(5);
        chk("w2_err", 64'(err_cnt), 64'd2);
        chk("w2_sum", 64'(sum_abs_err), 64'd8);
        chk("w2_max", 64'(max_abs_err), 64'd4);
`ifdef MUL8_ERR_SQ_EN
        chk("w2_sq", 64'(sum_sq_err), 64'd32);
`endif

        // in_valid every other cycle; offers past the window are ignored.
        do_start();
        for (int i = 0; i < 12; i++)
            cycle(1'(i % 2 == 0), i + 1, i + 2, (i + 1) * (i + 2) + i, 1'b0, 1'b0);
        idle(3);
        chk("w3_cnt", 64'(sample_cnt), 64'd4);

        // Restart mid-run discards two in-flight errored samples.
        do_start();
        cycle(1'b1, 4, 4, 9, 1'b0, 1'b0);
        cycle(1'b1, 2, 2, 5, 1'b0, 1'b0);
        do_start();
        for (int i = 0; i < 4; i++) rnd_sample(1'b0);
        idle(5);

        // Start together with the last accept: that sample is dropped.
        do_start();
        for (int i = 0; i < 3; i++) rnd_sample(1'b0);
        rnd_sample(1'b1);
        for (int i = 0; i < 4; i++) rnd_sample(1'b0);
        idle(5);

        // Reset during drain, then a clean window.
        do_start();
        for (int i = 0; i < 4; i++) rnd_sample(1'b0);
        idle(1);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
        chk("rst_cnt", 64'(sample_cnt), 64'd0);
        idle(2);
        do_start();
        for (int i = 0; i < 4; i++) rnd_sample(1'b0);
        idle(5);
        chk("w6_done", 64'(done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
